alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Arithmetic/logic execution stage directly upstream of the flag register.
- Accepts an opcode and two operands on a start pulse and returns the result and carry-out on its data outputs.
- Pulses enaf for exactly one cycle when the result is valid, so the flag register captures C/N/Z/P from the same values.
- Single-cycle ops complete in 1 clock. Shifts and multiply are iterative, one step per clock.

Parameters:
- MAX_WIDTH, 8, datapath width. Must be a power of two, >= 4.
- CNT_W, $clog2(MAX_WIDTH), width of the shift-count field taken from datab. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- start  in  1  request; sampled only while busy=0
- op  in  4  opcode, latched at accepted start
- dataa  in  MAX_WIDTH  operand A, latched at accepted start
- datab  in  MAX_WIDTH  operand B, latched at accepted start; datab[CNT_W-1:0] is the shift/rotate count
- result  out  MAX_WIDTH  registered result; holds between operations
- carry  out  1  registered carry-out; holds between operations
- enaf  out  1  one-cycle pulse, coincident with done; drives flag-register enaf
- done  out  1  one-cycle completion pulse
- busy  out  1  high while a multi-cycle op is in progress

Behaviour:
- Reset (rst=0, async): result=0, carry=0, enaf=0, done=0, busy=0, state=IDLE, internal counters/operand regs cleared.
- Reset mid-operation aborts the op; no done or enaf pulse follows the reset release.
- States: IDLE, SHIFT, MUL.
- Accept rule: start=1 at a clock edge with state=IDLE. start while busy=1 is ignored (not queued). Operand/op changes after acceptance have no effect.
- Opcode map:
  - 0 PASS: A, carry 0
  - 1 ADD: A+B, carry=carry-out
  - 2 SUB: A-B, carry=1 when no borrow (A>=B)
  - 3 AND, 4 OR, 5 XOR, 6 NOT A: carry 0
  - 7 INC: A+1, carry=carry-out
  - 8 SHL: logical shift left
  - 9 SHR: logical shift right
  - 10 MUL: unsigned multiply
  - 11 ROL, 12 ROR: see Optional Feature
  - 13-15 reserved
- Single-cycle ops (0-7, reserved, count-0 shifts): result/carry loaded at the accept edge; done=enaf=1 for the following cycle. State stays IDLE, so back-to-back starts on consecutive cycles are legal.
- Reserved opcodes: result=A, carry=0, latency 1.
- SHL/SHR: count n=datab[CNT_W-1:0].
  - n=0: result=A, carry=0, latency 1.
  - n>0: enter SHIFT with busy=1. Shift one bit per edge, zero fill, carry=last bit shifted out.
  - Result, done and enaf are registered at the edge of the n-th shift; state returns to IDLE, busy=0. Latency n+1 edges from accept.
- MUL: enter MUL with busy=1. Shift-add over exactly MAX_WIDTH iterations, one per edge, latency MAX_WIDTH+1.
  - result = low MAX_WIDTH bits of product.
  - carry = 1 if high half is non-zero.
- result/carry update only at completion. During busy they hold the previous op's values.
- done and enaf are never high for more than one consecutive cycle per op, and never asserted while busy=1.

Optional Feature:
- Macro: ALU_ROTATE_EN.
- Defined: op 11 ROL and op 12 ROR use the SHIFT state with count n=datab[CNT_W-1:0], same latency rules as shifts.
  - Each step moves the bit leaving one end into the other end.
  - carry = last bit moved. n=0 gives result=A, carry 0.
- Undefined: ops 11 and 12 are reserved (result=A, carry=0, latency 1). No rotate logic is synthesized.

Test Plan:
- ADD A=0xFF, B=0x01, start 1 cycle -> next cycle result=0x00, carry=1, done=enaf=1 for exactly 1 cycle, busy stays 0.
- SUB A=0x05, B=0x07 -> result=0xFE, carry=0. Then back-to-back SUB A=0x07, B=0x05 on the next cycle -> result=0x02, carry=1.
- SHR A=0x81, B=0x01 -> busy 1 cycle, done 2 edges after accept, result=0x40, carry=1.
  - SHL A=0x81, B=0x03 -> result=0x08, carry=0 at edge 4.
- MUL A=0x10, B=0x11 -> busy 8 cycles, result=0x10, carry=1 at edge 9.
  - A start pulse with op=ADD during busy is ignored: no extra done, result unchanged afterward.
- Assert rst=0 during MUL iteration 4 -> outputs immediately 0, busy=0. After release no done/enaf until a new start.
- ROL A=0x81, B=0x01 -> with ALU_ROTATE_EN: result=0x03, carry=1, latency 2. Without: result=0x81, carry=0, latency 1.

Source files
------------

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer_if
// Purpose  : Request/result bundle between an issuer (master) and the
//            alu_sequencer execution stage (slave).
// Revision : 1.0  initial release
// ============================================================================
interface alu_sequencer_if #(
    parameter int MAX_WIDTH = 8
);
    logic                 start;
    logic [3:0]           op;
    logic [MAX_WIDTH-1:0] dataa;
    logic [MAX_WIDTH-1:0] datab;
    logic [MAX_WIDTH-1:0] result;
    logic                 carry;
    logic                 enaf;
    logic                 done;
    logic                 busy;

    // Issuer side: drives the request, observes the result
    modport master (
        output start, op, dataa, datab,
        input  result, carry, enaf, done, busy
    );

    // Execution-stage side
    modport slave (
        input  start, op, dataa, datab,
        output result, carry, enaf, done, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : ALU execution stage feeding the flag register. Single-cycle
//            arithmetic/logic ops, iterative shifts (one bit per clock) and a
//            shift-add unsigned multiply (one step per clock).
// Options  : ALU_ROTATE_EN - when defined, op 11 ROL / op 12 ROR run through
//            the SHIFT state; otherwise they behave as reserved opcodes.
// Revision : 1.0  initial release
// ============================================================================
module alu_sequencer #(
    parameter int MAX_WIDTH = 8
) (
    input  wire              clk,
    input  wire              rst,     // asynchronous, active-low
    alu_sequencer_if.slave   bus
);
    localparam int CNT_W = $clog2(MAX_WIDTH);

    localparam logic [3:0] c_OP_PASS = 4'd0;
    localparam logic [3:0] c_OP_ADD  = 4'd1;
    localparam logic [3:0] c_OP_SUB  = 4'd2;
    localparam logic [3:0] c_OP_AND  = 4'd3;
    localparam logic [3:0] c_OP_OR   = 4'd4;
    localparam logic [3:0] c_OP_XOR  = 4'd5;
    localparam logic [3:0] c_OP_NOT  = 4'd6;
    localparam logic [3:0] c_OP_INC  = 4'd7;
    localparam logic [3:0] c_OP_SHL  = 4'd8;
    localparam logic [3:0] c_OP_SHR  = 4'd9;
    localparam logic [3:0] c_OP_MUL  = 4'd10;
`ifdef ALU_ROTATE_EN
    localparam logic [3:0] c_OP_ROL  = 4'd11;
    localparam logic [3:0] c_OP_ROR  = 4'd12;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MUL   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             op_q, op_d;
    logic [MAX_WIDTH-1:0]   sh_q, sh_d;        // value being shifted/rotated
    logic [CNT_W-1:0]       cnt_q, cnt_d;      // remaining steps minus one
    logic [MAX_WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*MAX_WIDTH-1:0] prod_q, prod_d;    // {partial high, multiplier/low}
    logic [MAX_WIDTH-1:0]   result_q, result_d;
    logic                   carry_q, carry_d;
    logic                   done_q, done_d;

    logic [MAX_WIDTH:0]     w_sum, w_diff, w_inc, w_mul_add;
    logic [MAX_WIDTH-1:0]   w_alu_res, w_sh_next;
    logic                   w_alu_c, w_sh_out, w_is_shift;
    logic [CNT_W-1:0]       w_cnt_in;
    logic [2*MAX_WIDTH-1:0] w_prod_next;

    assign w_sum    = {1'b0, bus.dataa} + {1'b0, bus.datab};
    assign w_diff   = {1'b0, bus.dataa} - {1'b0, bus.datab};
    assign w_inc    = {1'b0, bus.dataa} + (MAX_WIDTH+1)'(1);
    assign w_cnt_in = bus.datab[CNT_W-1:0];

    // One shift-add step: conditionally add multiplicand to the high half,
    // then shift the whole product right, keeping the add's carry bit.
    assign w_mul_add   = {1'b0, prod_q[2*MAX_WIDTH-1:MAX_WIDTH]}
                       + {1'b0, (prod_q[0] ? mcand_q : {MAX_WIDTH{1'b0}})};
    assign w_prod_next = {w_mul_add, prod_q[MAX_WIDTH-1:1]};

    // Single-cycle result; shifts with count 0 and reserved ops fall to PASS
    always_comb begin
        w_alu_res  = bus.dataa;
        w_alu_c    = 1'b0;
        w_is_shift = 1'b0;
        case (bus.op)
            c_OP_ADD: {w_alu_c, w_alu_res} = w_sum;
            c_OP_SUB: begin
                w_alu_res = w_diff[MAX_WIDTH-1:0];
                w_alu_c   = ~w_diff[MAX_WIDTH];   // 1 = no borrow
            end
            c_OP_AND: w_alu_res = bus.dataa & bus.datab;
            c_OP_OR:  w_alu_res = bus.dataa | bus.datab;
            c_OP_XOR: w_alu_res = bus.dataa ^ bus.datab;
            c_OP_NOT: w_alu_res = ~bus.dataa;
            c_OP_INC: {w_alu_c, w_alu_res} = w_inc;
            c_OP_SHL, c_OP_SHR: w_is_shift = 1'b1;
`ifdef ALU_ROTATE_EN
            c_OP_ROL, c_OP_ROR: w_is_shift = 1'b1;
`endif
            default: ;
        endcase
    end

    // One shift/rotate step on the latched value, with the bit moved out
    always_comb begin
        w_sh_next = {sh_q[MAX_WIDTH-2:0], 1'b0};
        w_sh_out  = sh_q[MAX_WIDTH-1];
        case (op_q)
            c_OP_SHR: begin
                w_sh_next = {1'b0, sh_q[MAX_WIDTH-1:1]};
                w_sh_out  = sh_q[0];
            end
`ifdef ALU_ROTATE_EN
            c_OP_ROL: w_sh_next = {sh_q[MAX_WIDTH-2:0], sh_q[MAX_WIDTH-1]};
            c_OP_ROR: begin
                w_sh_next = {sh_q[0], sh_q[MAX_WIDTH-1:1]};
                w_sh_out  = sh_q[0];
            end
`endif
            default: ;
        endcase
    end

    // Next-state and datapath control; outputs only move at completion
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        result_d = result_q;
        carry_d  = carry_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d = bus.op;
                    if (w_is_shift && (w_cnt_in != '0)) begin
                        state_d = S_SHIFT;
                        sh_d    = bus.dataa;
                        cnt_d   = w_cnt_in - CNT_W'(1);
                    end else if (bus.op == c_OP_MUL) begin
                        state_d = S_MUL;
                        mcand_d = bus.dataa;
                        prod_d  = {{MAX_WIDTH{1'b0}}, bus.datab};
                        cnt_d   = CNT_W'(MAX_WIDTH-1);
                    end else begin
                        result_d = w_alu_res;
                        carry_d  = w_alu_c;
                        done_d   = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                sh_d  = w_sh_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    result_d = w_sh_next;
                    carry_d  = w_sh_out;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_MUL: begin
                prod_d = w_prod_next;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    result_d = w_prod_next[MAX_WIDTH-1:0];
                    carry_d  = |w_prod_next[2*MAX_WIDTH-1:MAX_WIDTH];
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            sh_q     <= '0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.carry  = carry_q;
    assign bus.done   = done_q;
    assign bus.enaf   = done_q;
    assign bus.busy   = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Directed self-checking bench for alu_sequencer with a queue of
//            expected results (value, carry, latency) popped at each done.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;
    typedef struct {
        logic [7:0] res;
        logic       c;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    logic [7:0] held = 8'h00;   // result the DUT must hold while busy

    alu_sequencer_if #(.MAX_WIDTH(8)) bus ();

    alu_sequencer #(.MAX_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, wait (bounded) for done, compare against the scoreboard.
    // A poke_at value >= 1 injects an ADD start at that cycle of the wait.
    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] er, input logic ec, input int elat,
                          input int poke_at);
        int   lat;
        exp_t e;
        sb.push_back('{er, ec, elat});
        bus.start = 1'b1; bus.op = op; bus.dataa = a; bus.datab = b;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 4'd1; bus.dataa = ~a; bus.datab = ~b;
        lat = 1;
        while (!bus.done && lat < 40) begin
            chk("busy_during_op", 16'(bus.busy), 16'd1);
            chk("result_hold", 16'(bus.result), 16'(held));
            chk("enaf_while_busy", 16'(bus.enaf), 16'd0);
            bus.start = (lat == poke_at);
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        e = sb.pop_front();
        chk("done", 16'(bus.done), 16'd1);
        chk("enaf", 16'(bus.enaf), 16'd1);
        chk("busy_at_done", 16'(bus.busy), 16'd0);
        chk("result", 16'(bus.result), 16'(e.res));
        chk("carry", 16'(bus.carry), 16'(e.c));
        chk("latency", 16'(lat), 16'(e.lat));
        held = e.res;
        @(negedge clk);
        chk("done_one_cycle", 16'(bus.done), 16'd0);
        chk("enaf_one_cycle", 16'(bus.enaf), 16'd0);
    endtask

    initial begin
        exp_t e;
        int   seen;
        bus.start = 1'b0; bus.op = 4'd0; bus.dataa = 8'h00; bus.datab = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_result", 16'(bus.result), 16'h00);
        chk("rst_carry", 16'(bus.carry), 16'd0);
        chk("rst_done", 16'(bus.done), 16'd0);
        chk("rst_enaf", 16'(bus.enaf), 16'd0);
        chk("rst_busy", 16'(bus.busy), 16'd0);

        run_op(4'd1, 8'hFF, 8'h01, 8'h00, 1'b1, 1, 0);   // ADD wrap
        run_op(4'd1, 8'h12, 8'h34, 8'h46, 1'b0, 1, 0);   // ADD no carry

        // Back-to-back SUBs on consecutive cycles
        sb.push_back('{8'hFE, 1'b0, 1});
        sb.push_back('{8'h02, 1'b1, 1});
        bus.start = 1'b1; bus.op = 4'd2; bus.dataa = 8'h05; bus.datab = 8'h07;
        @(negedge clk);
        bus.dataa = 8'h07; bus.datab = 8'h05;
        e = sb.pop_front();
        chk("sub1_done", 16'(bus.done), 16'd1);
        chk("sub1_result", 16'(bus.result), 16'(e.res));
        chk("sub1_carry", 16'(bus.carry), 16'(e.c));
        @(negedge clk);
        bus.start = 1'b0;
        e = sb.pop_front();
        chk("sub2_done", 16'(bus.done), 16'd1);
        chk("sub2_busy", 16'(bus.busy), 16'd0);
        chk("sub2_result", 16'(bus.result), 16'(e.res));
        chk("sub2_carry", 16'(bus.carry), 16'(e.c));
        held = e.res;
        @(negedge clk);
        chk("sub2_done_pulse", 16'(bus.done), 16'd0);

        run_op(4'd0, 8'hA5, 8'h00, 8'hA5, 1'b0, 1, 0);   // PASS
        run_op(4'd3, 8'hF0, 8'h3C, 8'h30, 1'b0, 1, 0);   // AND
        run_op(4'd4, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1, 0);   // OR
        run_op(4'd5, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1, 0);   // XOR
        run_op(4'd6, 8'h5A, 8'h00, 8'hA5, 1'b0, 1, 0);   // NOT
        run_op(4'd7, 8'hFF, 8'h00, 8'h00, 1'b1, 1, 0);   // INC wrap
        run_op(4'd13, 8'h3C, 8'hFF, 8'h3C, 1'b0, 1, 0);  // reserved

        run_op(4'd9, 8'h81, 8'h01, 8'h40, 1'b1, 2, 0);   // SHR 1
        run_op(4'd8, 8'h81, 8'h03, 8'h08, 1'b0, 4, 0);   // SHL 3
        run_op(4'd8, 8'h81, 8'h00, 8'h81, 1'b0, 1, 0);   // SHL count 0
        run_op(4'd8, 8'h81, 8'h09, 8'h02, 1'b1, 2, 0);   // count uses low bits
        run_op(4'd9, 8'hF0, 8'h07, 8'h01, 1'b1, 8, 0);   // SHR max count

        run_op(4'd10, 8'h03, 8'h05, 8'h0F, 1'b0, 9, 0);  // MUL small
        run_op(4'd10, 8'hFF, 8'hFF, 8'h01, 1'b1, 9, 0);  // MUL max
        run_op(4'd10, 8'h10, 8'h11, 8'h10, 1'b1, 9, 3);  // MUL with ignored start
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done || bus.enaf) seen++;
        end
        chk("ignored_start_no_done", 16'(seen), 16'd0);
        chk("ignored_start_result", 16'(bus.result), 16'h10);

`ifdef ALU_ROTATE_EN
        run_op(4'd11, 8'h81, 8'h01, 8'h03, 1'b1, 2, 0);  // ROL
        run_op(4'd12, 8'h81, 8'h01, 8'hC0, 1'b1, 2, 0);  // ROR
`else
        run_op(4'd11, 8'h81, 8'h01, 8'h81, 1'b0, 1, 0);  // reserved ROL
        run_op(4'd12, 8'h81, 8'h01, 8'h81, 1'b0, 1, 0);  // reserved ROR
`endif

        // Abort a MUL during its fourth iteration with reset
        bus.start = 1'b1; bus.op = 4'd10; bus.dataa = 8'h10; bus.datab = 8'h11;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_abort_busy", 16'(bus.busy), 16'd1);
        rst = 1'b0;
        #1;
        chk("abort_result", 16'(bus.result), 16'h00);
        chk("abort_carry", 16'(bus.carry), 16'd0);
        chk("abort_busy", 16'(bus.busy), 16'd0);
        chk("abort_done", 16'(bus.done), 16'd0);
        @(negedge clk);
        rst = 1'b1;
        held = 8'h00;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.enaf || bus.busy) seen++;
        end
        chk("no_done_after_abort", 16'(seen), 16'd0);

        run_op(4'd1, 8'h01, 8'h02, 8'h03, 1'b0, 1, 0);   // recovers after reset
        chk("scoreboard_empty", 16'(sb.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
